// File: rtl/apple_spawner.sv
// apple_spawner: places an apple on a pseudo-random free playfield cell,
// detects when the snake head reaches it, requests growth via add_cube,
// flags scan pixels inside the apple cell and counts eaten apples.
module apple_spawner #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_TRIES = 64,
  parameter int unsigned ADD_HOLD  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_status,
  input  logic [5:0] head_x,
  input  logic [5:0] head_y,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic [5:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple_valid,
  output logic       add_cube,
  output logic       apple_pixel,
  output logic [7:0] eat_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPAWN,
    S_WAIT,
    S_EAT
  } state_t;

  localparam logic [5:0] TRIES_LAST = 6'(MAX_TRIES - 1);
  localparam logic [3:0] HOLD_INIT  = 4'(ADD_HOLD - 1);

  state_t      state;
  logic [15:0] lfsr;
  logic [5:0]  tries;
  logic [3:0]  hold_cnt;

  logic        is_play;
  logic        is_restart;
  logic [5:0]  cand_x;
  logic [5:0]  cand_y;
  logic        cand_ok;
  logic        head_on_apple;

  // Saturating increment for the eaten-apple counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next state of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign is_play       = (game_status == 2'b10);
  assign is_restart    = (game_status == 2'b00);
  assign cand_x        = lfsr[5:0];
  assign cand_y        = {1'b0, lfsr[12:8]};
  assign cand_ok       = (cand_x >= 6'd1) && (cand_x <= 6'd34) &&
                         (cand_y >= 6'd1) && (cand_y <= 6'd24) &&
                         !((cand_x == head_x) && (cand_y == head_y));
  assign head_on_apple = (head_x == apple_x) && (head_y == apple_y);

  // Free-running LFSR; only rst reseeds it, game status never stalls it.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  // Spawn / wait / eat controller with registered outputs.
  always_ff @(posedge clk) begin
    if (rst || is_restart) begin
      state       <= S_IDLE;
      apple_x     <= 6'd0;
      apple_y     <= 6'd0;
      apple_valid <= 1'b0;
      add_cube    <= 1'b0;
      eat_count   <= 8'd0;
      tries       <= 6'd0;
      hold_cnt    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          apple_x     <= 6'd0;
          apple_y     <= 6'd0;
          apple_valid <= 1'b0;
          add_cube    <= 1'b0;
          eat_count   <= 8'd0;
          if (is_play) begin
            state <= S_SPAWN;
            tries <= 6'd0;
          end
        end
        S_SPAWN: begin
          if (is_play) begin
            if (cand_ok) begin
              apple_x     <= cand_x;
              apple_y     <= cand_y;
              apple_valid <= 1'b1;
              state       <= S_WAIT;
            end else if (tries == TRIES_LAST) begin
              // Mirror of the head cell: always inside the field, never the head.
              apple_x     <= 6'd35 - head_x;
              apple_y     <= 6'd25 - head_y;
              apple_valid <= 1'b1;
              state       <= S_WAIT;
            end else begin
              tries <= tries + 6'd1;
            end
          end
        end
        S_WAIT: begin
          if (is_play && head_on_apple) begin
            add_cube    <= 1'b1;
            apple_valid <= 1'b0;
            eat_count   <= sat_inc8(eat_count);
            hold_cnt    <= HOLD_INIT;
            state       <= S_EAT;
          end
        end
        S_EAT: begin
          // Runs to completion even when frozen so the grow pulse is never cut short.
          if (hold_cnt == 4'd0) begin
            add_cube <= 1'b0;
            tries    <= 6'd0;
            state    <= S_SPAWN;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign apple_pixel = apple_valid &&
                       (x_pos < 10'd640) && (y_pos < 10'd480) &&
                       (x_pos[9:4] == apple_x) && (y_pos[9:4] == apple_y);

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner: reset/idle, spawn prediction from an
// LFSR reference, eat pulse, freeze, restart mid-eat, saturation, fallback
// placement and apple_pixel decoding.
module tb_apple_spawner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gs;
  logic [5:0] head_x, head_y;
  logic [9:0] x_pos, y_pos;
  logic [5:0] apple_x, apple_y;
  logic       apple_valid, add_cube, apple_pixel;
  logic [7:0] eat_count;

  logic       rst2;
  logic [1:0] gs2;
  logic [5:0] head2_x, head2_y;
  logic [5:0] apple2_x, apple2_y;
  logic       apple2_valid, add2_cube, apple2_pixel;
  logic [7:0] eat2_count;

  logic [15:0] m_lfsr;
  int          total = 0;
  int          bad   = 0;
  logic [5:0]  ex, ey, ax, ay;
  bit          wait_ok;

  always #5 clk = ~clk;

  apple_spawner dut (
    .clk(clk), .rst(rst), .game_status(gs), .head_x(head_x), .head_y(head_y),
    .x_pos(x_pos), .y_pos(y_pos), .apple_x(apple_x), .apple_y(apple_y),
    .apple_valid(apple_valid), .add_cube(add_cube), .apple_pixel(apple_pixel),
    .eat_count(eat_count)
  );

  apple_spawner #(.LFSR_SEED(16'h003F), .MAX_TRIES(1), .ADD_HOLD(4)) dut2 (
    .clk(clk), .rst(rst2), .game_status(gs2), .head_x(head2_x), .head_y(head2_y),
    .x_pos(x_pos), .y_pos(y_pos), .apple_x(apple2_x), .apple_y(apple2_y),
    .apple_valid(apple2_valid), .add_cube(add2_cube), .apple_pixel(apple2_pixel),
    .eat_count(eat2_count)
  );

  function automatic logic [15:0] lnext(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic bit accept(input logic [5:0] cx, input logic [5:0] cy,
                                input logic [5:0] hx, input logic [5:0] hy);
    return (cx >= 6'd1) && (cx <= 6'd34) && (cy >= 6'd1) && (cy <= 6'd24) &&
           !((cx == hx) && (cy == hy));
  endfunction

  // Reference LFSR for the default-seed instance.
  always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lnext(m_lfsr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after the edge that entered SPAWN: predicts the placed
  // cell and the cycle it appears from the reference LFSR, then checks it.
  task automatic spawn_expect(input string tag, input logic [5:0] hx, input logic [5:0] hy,
                              output logic [5:0] px, output logic [5:0] py);
    logic [15:0] v;
    logic [5:0]  cx, cy;
    int          n;
    v  = m_lfsr;
    n  = 64;
    px = 6'd35 - hx;
    py = 6'd25 - hy;
    for (int t = 0; t < 64; t++) begin
      cx = v[5:0];
      cy = {1'b0, v[12:8]};
      if (accept(cx, cy, hx, hy)) begin
        px = cx;
        py = cy;
        n  = t + 1;
        break;
      end
      v = lnext(v);
    end
    for (int k = 1; k < n; k++) step();
    chk({tag, "_valid_before"}, 32'(apple_valid), 32'(0));
    step();
    chk({tag, "_valid"}, 32'(apple_valid), 32'(1));
    chk({tag, "_x"}, 32'(apple_x), 32'(px));
    chk({tag, "_y"}, 32'(apple_y), 32'(py));
  endtask

  initial begin
    rst = 1'b1; gs = 2'b00; head_x = 6'd0; head_y = 6'd0;
    x_pos = 10'd0; y_pos = 10'd0;
    rst2 = 1'b1; gs2 = 2'b00; head2_x = 6'd10; head2_y = 6'd5;

    // Reset and RESTART idle
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("idle_apple_x", 32'(apple_x), 32'(0));
    chk("idle_apple_y", 32'(apple_y), 32'(0));
    chk("idle_valid", 32'(apple_valid), 32'(0));
    chk("idle_add_cube", 32'(add_cube), 32'(0));
    chk("idle_eat_count", 32'(eat_count), 32'(0));
    chk("idle_pixel", 32'(apple_pixel), 32'(0));
    chk("idle_lfsr", 32'(dut.lfsr), 32'(m_lfsr));

    // First spawn with head (10,5)
    head_x = 6'd10; head_y = 6'd5; gs = 2'b10;
    step();
    spawn_expect("spawn1", 6'd10, 6'd5, ax, ay);

    // Eat: add_cube high for exactly four cycles
    head_x = ax; head_y = ay;
    step();
    chk("eat_add_c1", 32'(add_cube), 32'(1));
    chk("eat_count1", 32'(eat_count), 32'(1));
    chk("eat_valid_low", 32'(apple_valid), 32'(0));
    step(); chk("eat_add_c2", 32'(add_cube), 32'(1));
    step(); chk("eat_add_c3", 32'(add_cube), 32'(1));
    step(); chk("eat_add_c4", 32'(add_cube), 32'(1));
    chk("eat_valid_low4", 32'(apple_valid), 32'(0));
    step(); chk("eat_add_drop", 32'(add_cube), 32'(0));
    spawn_expect("spawn2", ax, ay, ex, ey);

    // FREEZE with head on the apple: no eat, LFSR keeps running
    gs = 2'b01; head_x = ex; head_y = ey;
    for (int i = 0; i < 10; i++) step();
    chk("frz_add_cube", 32'(add_cube), 32'(0));
    chk("frz_valid", 32'(apple_valid), 32'(1));
    chk("frz_count", 32'(eat_count), 32'(1));
    chk("frz_lfsr", 32'(dut.lfsr), 32'(m_lfsr));

    // Resume: eat, then RESTART on the second add_cube cycle
    gs = 2'b10;
    step();
    chk("rs_add_c1", 32'(add_cube), 32'(1));
    chk("rs_count2", 32'(eat_count), 32'(2));
    step();
    chk("rs_add_c2", 32'(add_cube), 32'(1));
    gs = 2'b00;
    step();
    chk("rs_add_drop", 32'(add_cube), 32'(0));
    chk("rs_count0", 32'(eat_count), 32'(0));
    chk("rs_valid", 32'(apple_valid), 32'(0));
    chk("rs_apple_x", 32'(apple_x), 32'(0));
    chk("rs_apple_y", 32'(apple_y), 32'(0));

    // 256 eats: counter saturates at 255
    gs = 2'b10;
    for (int i = 0; i < 256; i++) begin
      wait_ok = 1'b0;
      for (int k = 0; k < 80; k++) begin
        if (apple_valid) begin
          wait_ok = 1'b1;
          break;
        end
        step();
      end
      if (!wait_ok) begin
        chk("sat_spawn_timeout", 32'(0), 32'(1));
        break;
      end
      head_x = apple_x; head_y = apple_y;
      step();
      chk("sat_count", 32'(eat_count), 32'(i < 255 ? i + 1 : 255));
    end
    chk("sat_final", 32'(eat_count), 32'(255));
    gs = 2'b00;
    step();
    chk("sat_restart", 32'(eat_count), 32'(0));

    // Fallback: seed 003F, MAX_TRIES=1, head (10,5) -> (25,20)
    gs2 = 2'b10; head2_x = 6'd10; head2_y = 6'd5;
    step();
    rst2 = 1'b0;
    step();
    chk("fb_valid_spawn", 32'(apple2_valid), 32'(0));
    step();
    chk("fb_valid", 32'(apple2_valid), 32'(1));
    chk("fb_x", 32'(apple2_x), 32'(25));
    chk("fb_y", 32'(apple2_y), 32'(20));

    // Fallback again with head (23,18) -> apple (12,7) for pixel checks
    rst2 = 1'b1; head2_x = 6'd23; head2_y = 6'd18;
    step();
    rst2 = 1'b0;
    step(); step();
    chk("px_apple_x", 32'(apple2_x), 32'(12));
    chk("px_apple_y", 32'(apple2_y), 32'(7));
    x_pos = 10'd192; y_pos = 10'd112; #1;
    chk("px_192_112", 32'(apple2_pixel), 32'(1));
    x_pos = 10'd207; y_pos = 10'd127; #1;
    chk("px_207_127", 32'(apple2_pixel), 32'(1));
    x_pos = 10'd200; y_pos = 10'd120; #1;
    chk("px_200_120", 32'(apple2_pixel), 32'(1));
    x_pos = 10'd208; y_pos = 10'd120; #1;
    chk("px_208_120", 32'(apple2_pixel), 32'(0));
    x_pos = 10'd191; y_pos = 10'd120; #1;
    chk("px_191_120", 32'(apple2_pixel), 32'(0));
    x_pos = 10'd200; y_pos = 10'd128; #1;
    chk("px_200_128", 32'(apple2_pixel), 32'(0));
    x_pos = 10'd200; y_pos = 10'd111; #1;
    chk("px_200_111", 32'(apple2_pixel), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
